// File: rtl/slot_credit_display.sv
// Credit/win display: synchronizes SPI-domain values, converts them to BCD with a
// double-dabble FSM, and scans five active-low digits. Optional macro: WIN_BLINK_EN.
module slot_credit_display #(
  parameter int SCAN_DIV  = 25000,
  parameter int WIN_HOLD  = 50000000,
  parameter int BLINK_DIV = 6250000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] total_credits,
  input  logic        is_total,
  input  logic [11:0] win_credits,
  input  logic        is_win,
  output logic [4:0]  select,
  output logic [6:0]  seven_segment_output
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = $clog2(WIN_HOLD + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        tot_sync_q, win_sync_q;
  logic [11:0]       tot_shadow_q, tot_shadow_d;
  logic [11:0]       win_shadow_q, win_shadow_d;
  logic              tot_pend_q, tot_pend_d;
  logic              win_pend_q, win_pend_d;
  logic [11:0]       bin_q, bin_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              src_q, src_d;
  logic [15:0]       tot_disp_q, tot_disp_d;
  logic [15:0]       win_disp_q, win_disp_d;
  logic              win_mode_q, win_mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [4:0]        sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;

  logic        tot_rise, win_rise;
  logic        tot_clr, win_clr;
  logic        load_tot, load_win;
  logic [15:0] adj;
  logic [15:0] act;
  logic        blink_blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Bit 1 is the synchronized level; bit 2 is its one-cycle-old copy for edge detection.
  assign tot_rise = tot_sync_q[1] & ~tot_sync_q[2];
  assign win_rise = win_sync_q[1] & ~win_sync_q[2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    tot_clr  = 1'b0;
    win_clr  = 1'b0;
    load_tot = 1'b0;
    load_win = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tot_pend_q) begin
          bin_d   = tot_shadow_q;
          src_d   = 1'b0;
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          tot_clr = 1'b1;
          state_d = ST_SHIFT;
        end else if (win_pend_q) begin
          bin_d   = win_shadow_q;
          src_d   = 1'b1;
          bcd_d   = 16'd0;
          cnt_d   = 4'd0;
          win_clr = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {adj[14:0], bin_q[11]};
        bin_d = {bin_q[10:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd11) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_tot = ~src_q;
        load_win = src_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge wins over the IDLE clear so a value arriving mid-start is never lost.
  always_comb begin
    tot_shadow_d = tot_rise ? total_credits : tot_shadow_q;
    win_shadow_d = win_rise ? win_credits : win_shadow_q;
    tot_pend_d   = tot_rise | (tot_pend_q & ~tot_clr);
    win_pend_d   = win_rise | (win_pend_q & ~win_clr);
    tot_disp_d   = load_tot ? bcd_q : tot_disp_q;
    win_disp_d   = load_win ? bcd_q : win_disp_q;
    win_mode_d   = win_mode_q;
    hold_d       = hold_q;
    if (load_win) begin
      win_mode_d = 1'b1;
      hold_d     = HOLD_W'(WIN_HOLD - 1);
    end else if (win_mode_q) begin
      if (hold_q == '0) win_mode_d = 1'b0;
      else              hold_d     = hold_q - HOLD_W'(1);
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
    end
  end

`ifdef WIN_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (load_win) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (win_mode_q) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign blink_blank = win_mode_q & blink_off_q;
`else
  assign blink_blank = 1'b0;
`endif

  assign act = win_mode_q ? win_disp_q : tot_disp_q;

  // Leading-zero blanking: a digit is blank when it and everything above it is zero.
  always_comb begin
    sel_d = ~(5'b00001 << idx_q);
    seg_d = SEG_BLANK;
    case (idx_q)
      3'd0: seg_d = seg7(act[3:0]);
      3'd1: seg_d = (act[15:4] == 12'd0) ? SEG_BLANK : seg7(act[7:4]);
      3'd2: seg_d = (act[15:8] == 8'd0) ? SEG_BLANK : seg7(act[11:8]);
      3'd3: seg_d = (act[15:12] == 4'd0) ? SEG_BLANK : seg7(act[15:12]);
      3'd4: seg_d = win_mode_q ? SEG_P : SEG_C;
      default: seg_d = SEG_BLANK;
    endcase
    if (blink_blank && idx_q != 3'd4) seg_d = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tot_sync_q   <= 3'b000;
      win_sync_q   <= 3'b000;
      tot_shadow_q <= 12'd0;
      win_shadow_q <= 12'd0;
      tot_pend_q   <= 1'b0;
      win_pend_q   <= 1'b0;
      bin_q        <= 12'd0;
      bcd_q        <= 16'd0;
      cnt_q        <= 4'd0;
      src_q        <= 1'b0;
      tot_disp_q   <= 16'd0;
      win_disp_q   <= 16'd0;
      win_mode_q   <= 1'b0;
      hold_q       <= '0;
      scan_cnt_q   <= '0;
      idx_q        <= 3'd0;
      sel_q        <= 5'b11111;
      seg_q        <= SEG_BLANK;
    end else begin
      state_q      <= state_d;
      tot_sync_q   <= {tot_sync_q[1:0], is_total};
      win_sync_q   <= {win_sync_q[1:0], is_win};
      tot_shadow_q <= tot_shadow_d;
      win_shadow_q <= win_shadow_d;
      tot_pend_q   <= tot_pend_d;
      win_pend_q   <= win_pend_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      tot_disp_q   <= tot_disp_d;
      win_disp_q   <= win_disp_d;
      win_mode_q   <= win_mode_d;
      hold_q       <= hold_d;
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign select               = sel_q;
  assign seven_segment_output = seg_q;

endmodule

// File: tb/tb_slot_credit_display.sv
// Directed bench for slot_credit_display with small scan/hold/blink dividers.
module tb_slot_credit_display;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] total_credits;
  logic        is_total;
  logic [11:0] win_credits;
  logic        is_win;
  logic [4:0]  select;
  logic [6:0]  seven_segment_output;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000, BL = 7'b1111111;
  localparam logic [6:0] SC = 7'b1000110, SP = 7'b0001100;

  always #5 clk = ~clk;

  slot_credit_display #(.SCAN_DIV(4), .WIN_HOLD(200), .BLINK_DIV(20)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .total_credits        (total_credits),
    .is_total             (is_total),
    .win_credits          (win_credits),
    .is_win               (is_win),
    .select               (select),
    .seven_segment_output (seven_segment_output)
  );

  // Advance n clocks, then settle 1 time unit past the edge for driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Collect one segment value per digit position, {d4,d3,d2,d1,d0}; ok=0 on timeout.
  task automatic capture(output logic [34:0] f, output bit ok);
    logic [4:0] want;
    logic [4:0] one;
    int t;
    ok = 1'b1;
    f  = '1;
    for (int k = 0; k < 5; k++) begin
      one  = 5'b00001;
      want = ~(one << k);
      t    = 0;
      @(negedge clk);
      while (select !== want && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (select !== want) ok = 1'b0;
      else f[7*k +: 7] = seven_segment_output;
    end
  endtask

  task automatic test_reset();
    int run;
    int bad_onehot;
    reset_n = 1'b0; total_credits = '0; is_total = 1'b0; win_credits = '0; is_win = 1'b0;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (select !== 5'b11111) begin n_bad++; $display("FAIL reset_select got %b want 11111", select); end
    n_cmp++;
    if (seven_segment_output !== BL) begin n_bad++; $display("FAIL reset_seg got %b want %b", seven_segment_output, BL); end
    tick(1);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (select !== 5'b11110) begin n_bad++; $display("FAIL release_select got %b want 11110", select); end
    n_cmp++;
    if (seven_segment_output !== S0) begin n_bad++; $display("FAIL release_seg got %b want %b", seven_segment_output, S0); end
    run = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (select === 5'b11110) run++;
      else break;
    end
    n_cmp++;
    if (run !== 4) begin n_bad++; $display("FAIL digit0_dwell got %0d want 4", run); end
    bad_onehot = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ($countones(~select) != 1) bad_onehot++;
    end
    n_cmp++;
    if (bad_onehot !== 0) begin n_bad++; $display("FAIL select_onehot got %0d bad cycles want 0", bad_onehot); end
    begin
      logic [34:0] f, e;
      bit ok;
      e = {SC, BL, BL, BL, S0};
      capture(f, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL idle_scan timeout"); end
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (f[7*k +: 7] !== e[7*k +: 7]) begin
          n_bad++; $display("FAIL idle_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
        end
      end
    end
  endtask

  task automatic test_total();
    logic [34:0] f, e;
    bit ok;
    tick(1);
    total_credits = 12'd1234; is_total = 1'b1;
    tick(20);
    is_total = 1'b0;
    e = {SC, S1, S2, S3, S4};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL total_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL total_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
  endtask

  task automatic test_win();
    logic [34:0] f, e;
    bit ok;
    total_credits = 12'd4095; is_total = 1'b1;
    tick(25);
    is_total = 1'b0;
    tick(2);
    win_credits = 12'd50; is_win = 1'b1;
    tick(25);
    is_win = 1'b0;
    e = {SP, BL, BL, S5, S0};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL win_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL win_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
    tick(200);
    e = {SC, S4, S0, S9, S5};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL revert_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL revert_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
  endtask

  task automatic test_both_same_cycle();
    logic [34:0] f, e;
    bit ok;
    tick(1);
    total_credits = 12'd7; win_credits = 12'd9;
    is_total = 1'b1; is_win = 1'b1;
    tick(40);
    is_total = 1'b0; is_win = 1'b0;
    e = {SP, BL, BL, BL, S9};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL both_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL both_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
    tick(250);
    e = {SC, BL, BL, BL, S7};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL both_after_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL both_after_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
  endtask

  task automatic test_total_during_win();
    logic [34:0] f, e;
    bit ok;
    tick(1);
    win_credits = 12'd20; is_win = 1'b1;
    tick(30);
    is_win = 1'b0;
    total_credits = 12'd8; is_total = 1'b1;
    tick(30);
    is_total = 1'b0;
    e = {SP, BL, BL, S2, S0};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tdw_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL tdw_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
    tick(250);
    e = {SC, BL, BL, BL, S8};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL tdw_after_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL tdw_after_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    logic [34:0] f, e;
    bit ok;
    tick(1);
    total_credits = 12'd999; is_total = 1'b1;
    tick(8);
    reset_n = 1'b0; is_total = 1'b0;
    tick(2);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (select !== 5'b11110) begin n_bad++; $display("FAIL midrst_select got %b want 11110", select); end
    n_cmp++;
    if (seven_segment_output !== S0) begin n_bad++; $display("FAIL midrst_seg got %b want %b", seven_segment_output, S0); end
    tick(30);
    e = {SC, BL, BL, BL, S0};
    capture(f, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL midrst_scan timeout"); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (f[7*k +: 7] !== e[7*k +: 7]) begin
        n_bad++; $display("FAIL midrst_digit%0d got %b want %b", k, f[7*k +: 7], e[7*k +: 7]);
      end
    end
  endtask

`ifdef WIN_BLINK_EN
  task automatic test_blink();
    logic [34:0] f;
    logic [6:0]  prev_d0;
    bit ok;
    tick(1);
    win_credits = 12'd8; is_win = 1'b1;
    tick(20);
    is_win = 1'b0;
    prev_d0 = 7'bx;
    for (int i = 0; i < 4; i++) begin
      capture(f, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL blink_scan%0d timeout", i); end
      n_cmp++;
      if (f[34:28] !== SP) begin n_bad++; $display("FAIL blink_p%0d got %b want %b", i, f[34:28], SP); end
      n_cmp++;
      if (f[6:0] !== S8 && f[6:0] !== BL) begin
        n_bad++; $display("FAIL blink_d0_%0d got %b want %b or %b", i, f[6:0], S8, BL);
      end
      if (i > 0) begin
        n_cmp++;
        if (f[6:0] === prev_d0) begin
          n_bad++; $display("FAIL blink_toggle%0d got %b want not %b", i, f[6:0], prev_d0);
        end
      end
      prev_d0 = f[6:0];
    end
  endtask
`endif

  initial begin
    test_reset();
    test_total();
    test_win();
    test_both_same_cycle();
    test_total_during_win();
    test_reset_mid_conversion();
`ifdef WIN_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
